// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch unit: reset/step constants
// and the prefetch FIFO entry layout.
// Optional build feature: FETCH_HALT_ON_ZERO_EN (see instr_fetch_unit.sv).
package if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] ZERO_INSTR       = 32'h0000_0000;

  // One buffered fetch: the word, where it came from, and whether that
  // address lies outside the instruction memory.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        oob;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush. Push into a full FIFO
// is accepted only when a pop happens on the same edge. The head is read
// straight from storage, so nothing pushed at an edge is visible before it.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign rdata    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: storage is reset because the head drives the fetch outputs
    // directly and those must read zero while reset is held.
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_eff && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational
// instruction memory, buffers words in a prefetch FIFO and hands them to
// decode over valid/ready. Execute redirects flush the buffer.
// Build option FETCH_HALT_ON_ZERO_EN: an all-zero word stops fetching
// (sticky until redirect or reset) and adds the fetch_halted output.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_oob,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
`ifdef FETCH_HALT_ON_ZERO_EN
  ,
  output logic        fetch_halted
`endif
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;
  localparam logic [31:0] OOB_LIMIT        = 32'(IMEM_WORDS) << 2;

  logic [31:0]  fetch_pc;
  logic         fifo_full;
  logic         fifo_empty;
  logic         do_pop;
  logic         do_push;
  logic         halted;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign imem_addr = fetch_pc;
  assign if_valid  = !fifo_empty;
  assign do_pop    = !fifo_empty && if_ready;
  // Redirect wins over fetching; a full FIFO still takes a word when its
  // head leaves on the same edge.
  assign do_push   = !redirect_valid && !halted && (!fifo_full || do_pop);

  assign if_instr  = head.instr;
  assign if_pc     = head.pc;
  assign if_oob    = head.oob;

  // Entry presented to the FIFO; the range flag is frozen at fetch time.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, here by
    // full assignment, so no latch can be inferred.
    push_entry.pc    = fetch_pc;
    push_entry.instr = imem_instr;
    push_entry.oob   = (fetch_pc >= OOB_LIMIT);
  end

  // Fetch PC: redirect target, else advance on each accepted fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              fetch_pc <= RESET_PC_ALIGNED;
    else if (redirect_valid) fetch_pc <= redirect_pc & PC_ALIGN_MASK;
    else if (do_push)        fetch_pc <= fetch_pc + PC_STEP;
  end

  // Count instructions accepted by decode, including on a redirect edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      fetch_count <= '0;
    else if (do_pop) fetch_count <= fetch_count + 32'd1;
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  // Sticky halt once a zero word has been pushed; redirect restarts fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     halted <= 1'b0;
    else if (redirect_valid)                        halted <= 1'b0;
    else if (do_push && (imem_instr == ZERO_INSTR)) halted <= 1'b1;
  end
  assign fetch_halted = halted;
`else
  assign halted = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (FIFO_DEPTH 2, IMEM_WORDS 64).
// Memory word i holds 0xA000_0000 | i except words 0/1; addresses past the
// memory return addr ^ 0xDEAD_0000.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_oob;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;
`ifdef FETCH_HALT_ON_ZERO_EN
  logic        fetch_halted;
`endif

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 32'd256) imem_instr = mem[imem_addr[7:2]];
    else                     imem_instr = imem_addr ^ 32'hDEAD_0000;
  end

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .IMEM_WORDS (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_oob         (if_oob),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_count    (fetch_count)
`ifdef FETCH_HALT_ON_ZERO_EN
    ,
    .fetch_halted   (fetch_halted)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h2008_0003;
    mem[1] = 32'h2009_0007;
`ifdef FETCH_HALT_ON_ZERO_EN
    mem[15] = 32'h0000_0000;
`endif
    reset          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    #1;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_oob", 32'(if_oob), 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    step();
    step();
    reset = 1'b1;

    // Streaming with if_ready high
    step();
    check("s1_valid", 32'(if_valid), 32'd1);
    check("s1_pc", if_pc, 32'h0);
    check("s1_instr", if_instr, 32'h2008_0003);
    check("s1_addr", imem_addr, 32'h4);
    step();
    check("s2_pc", if_pc, 32'h4);
    check("s2_instr", if_instr, 32'h2009_0007);
    step();
    check("s3_count", fetch_count, 32'd2);
    check("s3_pc", if_pc, 32'h8);

    // Asynchronous reset mid-run, then stall decode for 5 cycles
    reset = 1'b0;
    #1;
    check("ar_valid", 32'(if_valid), 32'd0);
    check("ar_instr", if_instr, 32'h0);
    check("ar_count", fetch_count, 32'd0);
    check("ar_addr", imem_addr, 32'h0);
    if_ready = 1'b0;
    reset    = 1'b1;
    step();
    step();
    step();
    check("stall3_pc", if_pc, 32'h0);
    step();
    step();
    check("stall_valid", 32'(if_valid), 32'd1);
    check("stall_pc", if_pc, 32'h0);
    check("stall_addr", imem_addr, 32'h8);
    if_ready = 1'b1;
    step();
    check("rel1_pc", if_pc, 32'h4);
    step();
    check("rel2_pc", if_pc, 32'h8);
    step();
    check("rel3_pc", if_pc, 32'hC);
    check("rel_count", fetch_count, 32'd3);

    // Redirect while full
    if_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0033;
    step();
    redirect_valid = 1'b0;
    check("rdf_valid", 32'(if_valid), 32'd0);
    check("rdf_addr", imem_addr, 32'h30);
    step();
    check("rdf_tgt_valid", 32'(if_valid), 32'd1);
    check("rdf_tgt_pc", if_pc, 32'h30);
    check("rdf_tgt_instr", if_instr, 32'hA000_000C);
    check("rdf_count", fetch_count, 32'd3);

    // Redirect together with a head accept
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    check("rda_count", fetch_count, 32'd4);
    check("rda_valid", 32'(if_valid), 32'd0);
    step();
    check("rda_pc", if_pc, 32'h40);
    check("rda_count2", fetch_count, 32'd4);

    // Out-of-range flag around the memory end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    step();
    check("oob1_pc", if_pc, 32'h100);
    check("oob1_flag", 32'(if_oob), 32'd1);
    step();
    check("oob2_flag", 32'(if_oob), 32'd1);
    check("oob2_instr", if_instr, 32'hDEAD_0104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_00FC;
    step();
    redirect_valid = 1'b0;
    step();
    check("edge_pc", if_pc, 32'hFC);
    check("edge_oob", 32'(if_oob), 32'd0);
    check("edge_instr", if_instr, 32'hA000_003F);
    step();
    check("edge_next_pc", if_pc, 32'h100);
    check("edge_next_oob", 32'(if_oob), 32'd1);
    check("oob_count", fetch_count, 32'd8);

    // PC wraps from the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);
    step();
    check("wrap_pc0", if_pc, 32'h0);
    check("wrap_instr", if_instr, 32'h2008_0003);
    check("wrap_oob", 32'(if_oob), 32'd0);

    // Back-to-back redirects: last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    step();
    check("bb1_valid", 32'(if_valid), 32'd0);
    redirect_pc = 32'h0000_0090;
    step();
    redirect_valid = 1'b0;
    check("bb2_valid", 32'(if_valid), 32'd0);
    check("bb2_addr", imem_addr, 32'h90);
    step();
    check("bb_pc", if_pc, 32'h90);
    check("bb_instr", if_instr, 32'hA000_0024);

`ifdef FETCH_HALT_ON_ZERO_EN
    // Halt on an all-zero word at 0x3C
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0038;
    step();
    redirect_valid = 1'b0;
    step();
    check("h_pc", if_pc, 32'h38);
    check("h_halted0", 32'(fetch_halted), 32'd0);
    step();
    check("h_zero_pc", if_pc, 32'h3C);
    check("h_zero_instr", if_instr, 32'h0);
    check("h_halted", 32'(fetch_halted), 32'd1);
    check("h_addr", imem_addr, 32'h40);
    step();
    check("h_drain_valid", 32'(if_valid), 32'd0);
    step();
    check("h_still_valid", 32'(if_valid), 32'd0);
    check("h_still_addr", imem_addr, 32'h40);
`endif

    // Fill the FIFO again, then reset mid-run
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_HALT_ON_ZERO_EN
    check("fin_halt_clr", 32'(fetch_halted), 32'd0);
`endif
    step();
    step();
    check("fin_valid", 32'(if_valid), 32'd1);
    check("fin_addr", imem_addr, 32'h8);
    reset = 1'b0;
    #1;
    check("fin_rst_valid", 32'(if_valid), 32'd0);
    check("fin_rst_pc", if_pc, 32'h0);
    check("fin_rst_instr", if_instr, 32'h0);
    check("fin_rst_oob", 32'(if_oob), 32'd0);
    check("fin_rst_count", fetch_count, 32'd0);
    check("fin_rst_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
